// File: rtl/frame_loader_pkg.sv
// -----------------------------------------------------------------------------
// frame_loader_pkg
//   Shared definitions for the frame loader slice:
//     state_e             - 3-bit FSM state encoding (IDLE, ARM, LOAD, DONE, ERR)
//     DEFAULT_STALL_LIMIT - idle LOAD cycles tolerated before a stall error
//     calc_target()       - words per frame from row length (bytes) and columns
// -----------------------------------------------------------------------------
package frame_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ARM  = 3'd1,
    ST_LOAD = 3'd2,
    ST_DONE = 3'd3,
    ST_ERR  = 3'd4
  } state_e;

  localparam int unsigned DEFAULT_STALL_LIMIT = 1024;

  // Frame size in bytes is length*columns, truncated to 32 bits. Each pipe
  // word carries two bytes, so an odd byte count rounds up to a whole word.
  // The +1 is done in 33 bits so an all-ones product cannot wrap to zero.
  function automatic logic [31:0] calc_target(input logic [31:0] len,
                                              input logic [31:0] cols);
    logic [31:0] prod;
    logic [32:0] sum;
    prod = len * cols;
    sum  = {1'b0, prod} + 33'd1;
    return sum[32:1];
  endfunction

endpackage

// File: rtl/frame_loader_if.sv
// -----------------------------------------------------------------------------
// frame_loader_if
//   Bundles the host pipe handshake and the frame-FIFO write side.
//   Handshake: a pipe word transfers in a cycle where pipe_in_write and
//   pipe_in_ready are both high at the rising edge of ti_clk; pipe_in_ready is
//   a pure function of loader state and fifo_full and never depends on
//   pipe_in_write. A write strobe without ready is dropped, not held.
//   The FIFO side is fire-and-forget: wr_en qualifies din for one cycle.
//   Ports:
//     ti_clk        - clock, shared with the loader
//   Modports:
//     master - host/FIFO side: drives pipe_in_write, pipe_in_data, fifo_full
//     slave  - loader side:    drives pipe_in_ready, din, wr_en
// -----------------------------------------------------------------------------
interface frame_loader_if #(
  parameter int unsigned WORD_W = 16
) (
  input logic ti_clk
);

  logic              pipe_in_write;
  logic [WORD_W-1:0] pipe_in_data;
  logic              pipe_in_ready;
  logic              fifo_full;
  logic [WORD_W-1:0] din;
  logic              wr_en;

  modport master (
    input  ti_clk,
    output pipe_in_write,
    output pipe_in_data,
    output fifo_full,
    input  pipe_in_ready,
    input  din,
    input  wr_en
  );

  modport slave (
    input  ti_clk,
    input  pipe_in_write,
    input  pipe_in_data,
    input  fifo_full,
    output pipe_in_ready,
    output din,
    output wr_en
  );

endinterface

// File: rtl/frame_stall_timer.sv
// -----------------------------------------------------------------------------
// frame_stall_timer
//   Counts consecutive enabled cycles without a clear. expired is asserted
//   combinationally during the STALL_LIMIT-th such cycle, so the owner can
//   change state on the edge that closes that cycle.
//   Ports:
//     ti_clk  - clock (rising edge)
//     rst     - asynchronous active-low reset
//     clear   - restart the count (wins over enable)
//     enable  - count this cycle
//     expired - this is the STALL_LIMIT-th consecutive enabled cycle
// -----------------------------------------------------------------------------
module frame_stall_timer
  import frame_loader_pkg::*;
#(
  parameter int unsigned STALL_LIMIT = DEFAULT_STALL_LIMIT
) (
  input  logic ti_clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned     CNT_W = $clog2(STALL_LIMIT + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(STALL_LIMIT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d   = cnt_q;
    expired = 1'b0;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      if (cnt_q == LAST) begin
        expired = 1'b1;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge ti_clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/frame_loader.sv
// -----------------------------------------------------------------------------
// frame_loader
//   Streams one frame of host pipe words into the downstream frame FIFO.
//   An arm pulse latches the frame size, then every accepted pipe word is
//   re-issued to the FIFO one cycle later. Dropped words and stalls raise
//   sticky flags that are cleared by the next arm.
//   Ports:
//     ti_clk, rst            - clock, asynchronous active-low reset
//     reg_length, reg_delay  - row length in bytes, number of columns
//     arm, abort             - single-cycle control pulses
//     pipe_in_write/_data    - host pipe word strobe and data
//     pipe_in_ready          - host may write this cycle
//     fifo_full              - downstream FIFO full
//     din, wr_en             - FIFO write data and strobe
//     words_loaded           - words written in the current load
//     load_done, busy        - in DONE / in ARM or LOAD
//     overflow, stall_err    - sticky dropped-word / stall-timeout flags
//     state_dbg              - current FSM state
// -----------------------------------------------------------------------------
module frame_loader
  import frame_loader_pkg::*;
#(
  parameter int unsigned WORD_W      = 16,
  parameter int unsigned STALL_LIMIT = DEFAULT_STALL_LIMIT
) (
  input  logic              ti_clk,
  input  logic              rst,
  input  logic [31:0]       reg_length,
  input  logic [31:0]       reg_delay,
  input  logic              arm,
  input  logic              abort,
  input  logic              pipe_in_write,
  input  logic [WORD_W-1:0] pipe_in_data,
  input  logic              fifo_full,
  output logic              pipe_in_ready,
  output logic [WORD_W-1:0] din,
  output logic              wr_en,
  output logic [31:0]       words_loaded,
  output logic              load_done,
  output logic              busy,
  output logic              overflow,
  output logic              stall_err,
  output state_e            state_dbg
);

  state_e            state_q,     state_d;
  logic [31:0]       target_q,    target_d;
  logic [31:0]       words_q,     words_d;
  logic              wr_en_q,     wr_en_d;
  logic [WORD_W-1:0] din_q,       din_d;
  logic              overflow_q,  overflow_d;
  logic              stall_err_q, stall_err_d;

  logic        in_load;
  logic        accept;
  logic        drop;
  logic        stall_expired;
  logic [31:0] arm_target;

  assign in_load       = (state_q == ST_LOAD);
  assign pipe_in_ready = in_load && !fifo_full;

  // words_q already counts a word accepted on the previous cycle, so once it
  // equals the target the frame is complete even though we are still in
  // LOAD for the final wr_en cycle; a write landing there is surplus and is
  // dropped. A write coinciding with abort is also refused so nothing is
  // emitted after the abort.
  assign accept = pipe_in_write && pipe_in_ready && !abort &&
                  (words_q < target_q);
  assign drop   = pipe_in_write && !accept;

  assign arm_target = calc_target(reg_length, reg_delay);

  frame_stall_timer #(
    .STALL_LIMIT (STALL_LIMIT)
  ) u_stall_timer (
    .ti_clk  (ti_clk),
    .rst     (rst),
    .clear   (!in_load || accept),
    .enable  (in_load),
    .expired (stall_expired)
  );

  always_comb begin
    state_d     = state_q;
    target_d    = target_q;
    words_d     = words_q;
    wr_en_d     = 1'b0;
    din_d       = din_q;
    overflow_d  = overflow_q;
    stall_err_d = stall_err_q;

    if (accept) begin
      wr_en_d = 1'b1;
      din_d   = pipe_in_data;
      words_d = words_q + 32'd1;
    end

    if (drop) begin
      overflow_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (arm && !abort) begin
          state_d = ST_ARM;
        end
      end

      ST_ARM: begin
        target_d    = arm_target;
        words_d     = 32'd0;
        // A word dropped during the ARM cycle itself still counts.
        overflow_d  = drop;
        stall_err_d = 1'b0;
        if (abort) begin
          state_d = ST_IDLE;
        end else if (arm_target == 32'd0) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_LOAD;
        end
      end

      ST_LOAD: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (words_q == target_q) begin
          state_d = ST_DONE;
        end else if (stall_expired) begin
          state_d     = ST_ERR;
          stall_err_d = 1'b1;
        end
      end

      ST_DONE, ST_ERR: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (arm) begin
          state_d = ST_ARM;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge ti_clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      target_q    <= 32'd0;
      words_q     <= 32'd0;
      wr_en_q     <= 1'b0;
      din_q       <= '0;
      overflow_q  <= 1'b0;
      stall_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      target_q    <= target_d;
      words_q     <= words_d;
      wr_en_q     <= wr_en_d;
      din_q       <= din_d;
      overflow_q  <= overflow_d;
      stall_err_q <= stall_err_d;
    end
  end

  assign wr_en        = wr_en_q;
  assign din          = din_q;
  assign words_loaded = words_q;
  assign load_done    = (state_q == ST_DONE);
  assign busy         = (state_q == ST_ARM) || (state_q == ST_LOAD);
  assign overflow     = overflow_q;
  assign stall_err    = stall_err_q;
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_frame_loader.sv
// -----------------------------------------------------------------------------
// tb_frame_loader
//   Scenario tasks drive the loader through its frame sizes, drop cases,
//   stall timeout, abort and asynchronous reset. Expected FIFO words are
//   queued as the host writes them and popped by the write monitor.
// -----------------------------------------------------------------------------
module tb_frame_loader;
  import frame_loader_pkg::*;

  localparam int unsigned WORD_W      = 16;
  localparam int unsigned STALL_LIMIT = 16;

  // ---------------- clock / reset ----------------
  logic ti_clk = 1'b0;
  logic rst;
  always #5 ti_clk = ~ti_clk;

  logic [31:0] reg_length;
  logic [31:0] reg_delay;
  logic        arm;
  logic        abort;
  logic [31:0] words_loaded;
  logic        load_done;
  logic        busy;
  logic        overflow;
  logic        stall_err;
  state_e      state_dbg;

  frame_loader_if #(.WORD_W(WORD_W)) pif (.ti_clk(ti_clk));

  frame_loader #(
    .WORD_W      (WORD_W),
    .STALL_LIMIT (STALL_LIMIT)
  ) dut (
    .ti_clk        (ti_clk),
    .rst           (rst),
    .reg_length    (reg_length),
    .reg_delay     (reg_delay),
    .arm           (arm),
    .abort         (abort),
    .pipe_in_write (pif.pipe_in_write),
    .pipe_in_data  (pif.pipe_in_data),
    .fifo_full     (pif.fifo_full),
    .pipe_in_ready (pif.pipe_in_ready),
    .din           (pif.din),
    .wr_en         (pif.wr_en),
    .words_loaded  (words_loaded),
    .load_done     (load_done),
    .busy          (busy),
    .overflow      (overflow),
    .stall_err     (stall_err),
    .state_dbg     (state_dbg)
  );

  // ---------------- scoreboard ----------------
  int chk_cnt  = 0;
  int pass_cnt = 0;
  int wr_cnt   = 0;
  logic [WORD_W-1:0] exp_q[$];
  logic [WORD_W-1:0] exp_w;

  always @(negedge ti_clk) begin
    if (pif.wr_en !== 1'b0) begin
      wr_cnt++;
      chk_cnt++;
      if (exp_q.size() == 0) begin
        $display("FAIL wr_unexpected: wr_en=%b din=%h, required no write", pif.wr_en, pif.din);
      end else begin
        exp_w = exp_q.pop_front();
        if (pif.din !== exp_w) begin
          $display("FAIL wr_din: din=%h, required %h", pif.din, exp_w);
        end else begin
          pass_cnt++;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required normal completion");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic next_cycle();
    @(posedge ti_clk);
    #1;
  endtask

  task automatic arm_frame(input logic [31:0] len, input logic [31:0] cols);
    reg_length = len;
    reg_delay  = cols;
    arm        = 1'b1;
    next_cycle();
    arm        = 1'b0;
  endtask

  task automatic write_word(input logic [WORD_W-1:0] d, input bit exp_acc);
    pif.pipe_in_write = 1'b1;
    pif.pipe_in_data  = d;
    if (exp_acc) exp_q.push_back(d);
    next_cycle();
    pif.pipe_in_write = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b0;
    reg_length = 32'd0;
    reg_delay  = 32'd0;
    arm = 1'b0;
    abort = 1'b0;
    pif.pipe_in_write = 1'b0;
    pif.pipe_in_data  = '0;
    pif.fifo_full     = 1'b0;
    repeat (2) next_cycle();
    chk_cnt++;
    if ({pif.wr_en, pif.din, words_loaded, load_done, busy, overflow, stall_err, pif.pipe_in_ready} !== 54'd0
        || state_dbg !== ST_IDLE) begin
      $display("FAIL reset_hold: outputs=%h state=%0d, required 0 and IDLE",
               {pif.wr_en, pif.din, words_loaded, load_done, busy, overflow, stall_err, pif.pipe_in_ready}, state_dbg);
    end else pass_cnt++;
    rst = 1'b1;
    next_cycle();
    chk_cnt++;
    if (busy !== 1'b0 || state_dbg !== ST_IDLE) begin
      $display("FAIL reset_release: busy=%b state=%0d, required 0 IDLE", busy, state_dbg);
    end else pass_cnt++;
  endtask

  task automatic test_basic();
    int base;
    base = wr_cnt;
    arm_frame(32'd8, 32'd3);
    chk_cnt++;
    if (state_dbg !== ST_ARM || busy !== 1'b1) begin
      $display("FAIL basic_arm: state=%0d busy=%b, required ARM 1", state_dbg, busy);
    end else pass_cnt++;
    next_cycle();
    chk_cnt++;
    if (pif.pipe_in_ready !== 1'b1 || words_loaded !== 32'd0) begin
      $display("FAIL basic_load: ready=%b words=%0d, required 1 0", pif.pipe_in_ready, words_loaded);
    end else pass_cnt++;
    for (int i = 1; i <= 12; i++) write_word(WORD_W'(i), 1'b1);
    chk_cnt++;
    if (words_loaded !== 32'd12 || load_done !== 1'b0) begin
      $display("FAIL basic_last_wr: words=%0d done=%b, required 12 0", words_loaded, load_done);
    end else pass_cnt++;
    next_cycle();
    chk_cnt++;
    if (load_done !== 1'b1 || busy !== 1'b0) begin
      $display("FAIL basic_done: done=%b busy=%b, required 1 0", load_done, busy);
    end else pass_cnt++;
    next_cycle();
    chk_cnt++;
    if (wr_cnt - base != 12 || exp_q.size() != 0 || load_done !== 1'b1) begin
      $display("FAIL basic_count: writes=%0d pending=%0d done=%b, required 12 0 1",
               wr_cnt - base, exp_q.size(), load_done);
    end else pass_cnt++;
  endtask

  task automatic test_overflow();
    int base;
    base = wr_cnt;
    arm_frame(32'd3, 32'd3);
    next_cycle();
    for (int i = 1; i <= 5; i++) write_word(WORD_W'(16'h0100 + i), 1'b1);
    chk_cnt++;
    if (overflow !== 1'b0) begin
      $display("FAIL ovf_before: overflow=%b, required 0", overflow);
    end else pass_cnt++;
    write_word(16'h0106, 1'b0);
    chk_cnt++;
    if (overflow !== 1'b1 || words_loaded !== 32'd5 || load_done !== 1'b1) begin
      $display("FAIL ovf_after: overflow=%b words=%0d done=%b, required 1 5 1",
               overflow, words_loaded, load_done);
    end else pass_cnt++;
    next_cycle();
    chk_cnt++;
    if (wr_cnt - base != 5) begin
      $display("FAIL ovf_count: writes=%0d, required 5", wr_cnt - base);
    end else pass_cnt++;
  endtask

  task automatic test_fifo_full();
    int base;
    base = wr_cnt;
    arm_frame(32'd4, 32'd4);
    next_cycle();
    chk_cnt++;
    if (overflow !== 1'b0) begin
      $display("FAIL full_arm_clear: overflow=%b, required 0", overflow);
    end else pass_cnt++;
    write_word(16'hA001, 1'b1);
    write_word(16'hA002, 1'b1);
    pif.fifo_full = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk_cnt++;
      if (pif.pipe_in_ready !== 1'b0) begin
        $display("FAIL full_ready: ready=%b, required 0", pif.pipe_in_ready);
      end else pass_cnt++;
      write_word(WORD_W'(16'hBB00 + k), 1'b0);
    end
    pif.fifo_full = 1'b0;
    chk_cnt++;
    if (overflow !== 1'b1 || words_loaded !== 32'd2) begin
      $display("FAIL full_drop: overflow=%b words=%0d, required 1 2", overflow, words_loaded);
    end else pass_cnt++;
    for (int i = 3; i <= 8; i++) write_word(WORD_W'(16'hA000 + i), 1'b1);
    next_cycle();
    chk_cnt++;
    if (wr_cnt - base != 8 || load_done !== 1'b1 || words_loaded !== 32'd8) begin
      $display("FAIL full_count: writes=%0d done=%b words=%0d, required 8 1 8",
               wr_cnt - base, load_done, words_loaded);
    end else pass_cnt++;
  endtask

  task automatic test_zero_target();
    int base;
    base = wr_cnt;
    arm_frame(32'd0, 32'd5);
    next_cycle();
    chk_cnt++;
    if (state_dbg !== ST_DONE || load_done !== 1'b1 || busy !== 1'b0) begin
      $display("FAIL zero_done: state=%0d done=%b busy=%b, required DONE 1 0", state_dbg, load_done, busy);
    end else pass_cnt++;
    repeat (3) next_cycle();
    chk_cnt++;
    if (wr_cnt - base != 0 || words_loaded !== 32'd0) begin
      $display("FAIL zero_writes: writes=%0d words=%0d, required 0 0", wr_cnt - base, words_loaded);
    end else pass_cnt++;
    // 1x1 bytes rounds up to a single word.
    arm_frame(32'd1, 32'd1);
    next_cycle();
    write_word(16'h5A5A, 1'b1);
    next_cycle();
    chk_cnt++;
    if (load_done !== 1'b1 || words_loaded !== 32'd1) begin
      $display("FAIL one_word: done=%b words=%0d, required 1 1", load_done, words_loaded);
    end else pass_cnt++;
  endtask

  task automatic test_target_latch();
    arm_frame(32'd2, 32'd2);
    next_cycle();
    reg_length = 32'd100;
    reg_delay  = 32'd100;
    write_word(16'h0C01, 1'b1);
    arm = 1'b1;
    next_cycle();
    arm = 1'b0;
    chk_cnt++;
    if (state_dbg !== ST_LOAD || words_loaded !== 32'd1) begin
      $display("FAIL latch_arm_ignored: state=%0d words=%0d, required LOAD 1", state_dbg, words_loaded);
    end else pass_cnt++;
    write_word(16'h0C02, 1'b1);
    next_cycle();
    chk_cnt++;
    if (load_done !== 1'b1 || words_loaded !== 32'd2) begin
      $display("FAIL latch_target: done=%b words=%0d, required 1 2", load_done, words_loaded);
    end else pass_cnt++;
  endtask

  task automatic test_abort();
    int base;
    base = wr_cnt;
    arm_frame(32'd4, 32'd4);
    next_cycle();
    for (int i = 1; i <= 3; i++) write_word(WORD_W'(16'hD000 + i), 1'b1);
    pif.pipe_in_write = 1'b1;
    pif.pipe_in_data  = 16'hDEAD;
    abort = 1'b1;
    next_cycle();
    abort = 1'b0;
    pif.pipe_in_write = 1'b0;
    chk_cnt++;
    if (state_dbg !== ST_IDLE || busy !== 1'b0 || words_loaded !== 32'd3) begin
      $display("FAIL abort_idle: state=%0d busy=%b words=%0d, required IDLE 0 3",
               state_dbg, busy, words_loaded);
    end else pass_cnt++;
    repeat (3) next_cycle();
    chk_cnt++;
    if (wr_cnt - base != 3 || words_loaded !== 32'd3) begin
      $display("FAIL abort_count: writes=%0d words=%0d, required 3 3", wr_cnt - base, words_loaded);
    end else pass_cnt++;
  endtask

  task automatic test_stall();
    arm_frame(32'd8, 32'd8);
    next_cycle();
    repeat (15) next_cycle();
    chk_cnt++;
    if (state_dbg !== ST_LOAD || stall_err !== 1'b0) begin
      $display("FAIL stall_early: state=%0d stall_err=%b, required LOAD 0", state_dbg, stall_err);
    end else pass_cnt++;
    next_cycle();
    chk_cnt++;
    if (state_dbg !== ST_ERR || stall_err !== 1'b1 || busy !== 1'b0 || pif.pipe_in_ready !== 1'b0) begin
      $display("FAIL stall_err: state=%0d stall_err=%b busy=%b ready=%b, required ERR 1 0 0",
               state_dbg, stall_err, busy, pif.pipe_in_ready);
    end else pass_cnt++;
    abort = 1'b1;
    next_cycle();
    abort = 1'b0;
    chk_cnt++;
    if (state_dbg !== ST_IDLE || stall_err !== 1'b1) begin
      $display("FAIL stall_abort: state=%0d stall_err=%b, required IDLE 1", state_dbg, stall_err);
    end else pass_cnt++;
    arm   = 1'b1;
    abort = 1'b1;
    next_cycle();
    arm   = 1'b0;
    abort = 1'b0;
    chk_cnt++;
    if (state_dbg !== ST_IDLE || busy !== 1'b0) begin
      $display("FAIL arm_abort_same: state=%0d busy=%b, required IDLE 0", state_dbg, busy);
    end else pass_cnt++;
  endtask

  task automatic test_reset_midload();
    arm_frame(32'd8, 32'd3);
    next_cycle();
    for (int i = 1; i <= 5; i++) write_word(WORD_W'(16'hE000 + i), 1'b1);
    next_cycle();
    chk_cnt++;
    if (words_loaded !== 32'd5 || busy !== 1'b1) begin
      $display("FAIL midload_pre: words=%0d busy=%b, required 5 1", words_loaded, busy);
    end else pass_cnt++;
    #2;
    rst = 1'b0;
    pif.pipe_in_write = 1'b1;
    pif.pipe_in_data  = 16'hBEEF;
    #1;
    chk_cnt++;
    if ({pif.wr_en, pif.din, words_loaded, load_done, busy, overflow, stall_err, pif.pipe_in_ready} !== 54'd0
        || state_dbg !== ST_IDLE) begin
      $display("FAIL midload_async: outputs=%h state=%0d, required 0 and IDLE",
               {pif.wr_en, pif.din, words_loaded, load_done, busy, overflow, stall_err, pif.pipe_in_ready}, state_dbg);
    end else pass_cnt++;
    repeat (2) next_cycle();
    chk_cnt++;
    if ({pif.wr_en, words_loaded, overflow, pif.pipe_in_ready} !== 35'd0) begin
      $display("FAIL midload_hold: wr_en=%b words=%0d overflow=%b ready=%b, required all 0",
               pif.wr_en, words_loaded, overflow, pif.pipe_in_ready);
    end else pass_cnt++;
    pif.pipe_in_write = 1'b0;
    rst = 1'b1;
    next_cycle();
    arm_frame(32'd5, 32'd2);
    next_cycle();
    chk_cnt++;
    if (state_dbg !== ST_LOAD || words_loaded !== 32'd0) begin
      $display("FAIL restart_clear: state=%0d words=%0d, required LOAD 0", state_dbg, words_loaded);
    end else pass_cnt++;
    write_word(16'hF001, 1'b1);
    write_word(16'hF002, 1'b1);
    chk_cnt++;
    if (words_loaded !== 32'd2) begin
      $display("FAIL restart_words: words=%0d, required 2", words_loaded);
    end else pass_cnt++;
    abort = 1'b1;
    next_cycle();
    abort = 1'b0;
    next_cycle();
    chk_cnt++;
    if (exp_q.size() != 0) begin
      $display("FAIL final_pending: pending=%0d, required 0", exp_q.size());
    end else pass_cnt++;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_fifo_full();
    test_zero_target();
    test_target_latch();
    test_abort();
    test_stall();
    test_reset_midload();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
